// File: rtl/load_dcache_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : load_dcache_ctrl_pkg
// Brief  : Shared types and encodings for the load-side data cache.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package load_dcache_ctrl_pkg;

    typedef enum logic [1:0] {
        BUS_NONE = 2'd0,
        BUS_LOAD = 2'd1
    } BUS_COMMAND;

    localparam logic [1:0] MEM_BYTE = 2'd0;
    localparam logic [1:0] MEM_HALF = 2'd1;
    localparam logic [1:0] MEM_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } DCACHE_STATE;

endpackage

`default_nettype wire

// File: rtl/load_dcache_ctrl_align.sv
//------------------------------------------------------------------------------
// Module : load_data_align
// Brief  : Selects a byte/half/word from a 64-bit line and sign/zero-extends it.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_data_align
    import load_dcache_ctrl_pkg::*;
(
    input  logic [63:0] line,
    input  logic [2:0]  off,
    input  logic [2:0]  mem_size,
    output logic [31:0] data,
    output logic        size_ok
);

    logic [31:0] w_word;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic        w_signed;

    // Accesses are naturally aligned, so a three-level mux replaces a full shifter.
    assign w_word   = off[2] ? line[63:32]    : line[31:0];
    assign w_half   = off[1] ? w_word[31:16]  : w_word[15:0];
    assign w_byte   = off[0] ? w_half[15:8]   : w_half[7:0];
    assign w_signed = ~mem_size[2];

    always_comb begin
        data    = 32'd0;
        size_ok = 1'b1;
        case (mem_size[1:0])
            MEM_BYTE: data = {{24{w_signed & w_byte[7]}}, w_byte};
            MEM_HALF: data = {{16{w_signed & w_half[15]}}, w_half};
            MEM_WORD: data = w_word;
            default:  size_ok = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_dcache_ctrl.sv
//------------------------------------------------------------------------------
// Module : load_dcache_ctrl
// Brief  : Blocking read-only direct-mapped data cache with single-miss fill FSM.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module load_dcache_ctrl
    import load_dcache_ctrl_pkg::*;
#(
    parameter int NUM_LINES = 32
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rd_cache,
    input  logic [31:0] addr,
    input  logic [2:0]  mem_size,
    input  logic        squash,
    output logic        cache_valid,
    output logic [31:0] cache_data,
    output logic [1:0]  proc2mem_command,
    output logic [31:0] proc2mem_addr,
    input  logic [3:0]  mem2proc_response,
    input  logic [63:0] mem2proc_data,
    input  logic [3:0]  mem2proc_tag,
    output logic [31:0] miss_count
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = 29 - IDX_W;

    logic [NUM_LINES-1:0] r_valid;
    logic [TAG_W-1:0]     r_tags  [NUM_LINES];
    logic [63:0]          r_lines [NUM_LINES];

    DCACHE_STATE  r_state;
    DCACHE_STATE  w_state_next;
    logic [28:0]  r_miss_line;
    logic [3:0]   r_mem_tag;
    logic [31:0]  r_miss_count;

    logic [IDX_W-1:0] w_idx;
    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_miss_idx;
    logic [TAG_W-1:0] w_miss_tag;
    logic             w_line_hit;
    logic [31:0]      w_align_data;
    logic             w_size_ok;
    logic             w_latch;
    logic             w_accept;
    logic             w_fill;

    assign w_idx      = addr[3 +: IDX_W];
    assign w_tag      = addr[31 -: TAG_W];
    assign w_miss_idx = r_miss_line[IDX_W-1:0];
    assign w_miss_tag = r_miss_line[28 -: TAG_W];
    assign w_line_hit = r_valid[w_idx] && (r_tags[w_idx] == w_tag);

    load_data_align u_align (
        .line     (r_lines[w_idx]),
        .off      (addr[2:0]),
        .mem_size (mem_size),
        .data     (w_align_data),
        .size_ok  (w_size_ok)
    );

    assign cache_valid = rd_cache && w_line_hit && w_size_ok;
    assign cache_data  = cache_valid ? w_align_data : 32'd0;
    assign miss_count  = r_miss_count;

    always_comb begin
        w_state_next     = r_state;
        proc2mem_command = BUS_NONE;
        proc2mem_addr    = 32'd0;
        w_latch          = 1'b0;
        w_accept         = 1'b0;
        w_fill           = 1'b0;
        case (r_state)
            IDLE: begin
                if (rd_cache && !w_line_hit) begin
                    w_latch      = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                proc2mem_command = BUS_LOAD;
                proc2mem_addr    = {r_miss_line, 3'b000};
                // An accepted request must complete even if squashed this cycle.
                if (mem2proc_response != 4'd0) begin
                    w_accept     = 1'b1;
                    w_state_next = WAIT;
                end else if (squash) begin
                    w_state_next = IDLE;
                end
            end
            WAIT: begin
                if ((mem2proc_tag == r_mem_tag) && (r_mem_tag != 4'd0)) begin
                    w_fill       = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_valid      <= '0;
            r_miss_line  <= '0;
            r_mem_tag    <= '0;
            r_miss_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_latch) begin
                r_miss_line <= addr[31:3];
            end
            if (w_accept) begin
                r_mem_tag <= mem2proc_response;
            end
            if (w_fill) begin
                r_valid[w_miss_idx] <= 1'b1;
                r_mem_tag           <= 4'd0;
                r_miss_count        <= r_miss_count + 32'd1;
            end
        end
    end

    // Line payload needs no reset; the valid bits guard it.
    always_ff @(posedge clock) begin
        if (w_fill) begin
            r_lines[w_miss_idx] <= mem2proc_data;
            r_tags[w_miss_idx]  <= w_miss_tag;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_load_dcache_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_load_dcache_ctrl
// Brief  : Directed self-checking bench for load_dcache_ctrl.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_load_dcache_ctrl;

    logic        clock;
    logic        reset_n;
    logic        rd_cache;
    logic [31:0] addr;
    logic [2:0]  mem_size;
    logic        squash;
    logic        cache_valid;
    logic [31:0] cache_data;
    logic [1:0]  proc2mem_command;
    logic [31:0] proc2mem_addr;
    logic [3:0]  mem2proc_response;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_misses = 0;

    localparam logic [1:0] CMD_NONE = 2'd0;
    localparam logic [1:0] CMD_LOAD = 2'd1;
    localparam logic [63:0] LINE_A = 64'h11223344_AABBCCDD;
    localparam logic [63:0] LINE_B = 64'h55667788_99AABBCC;

    load_dcache_ctrl #(.NUM_LINES(32)) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .rd_cache          (rd_cache),
        .addr              (addr),
        .mem_size          (mem_size),
        .squash            (squash),
        .cache_valid       (cache_valid),
        .cache_data        (cache_data),
        .proc2mem_command  (proc2mem_command),
        .proc2mem_addr     (proc2mem_addr),
        .mem2proc_response (mem2proc_response),
        .mem2proc_data     (mem2proc_data),
        .mem2proc_tag      (mem2proc_tag),
        .miss_count        (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rd;
        logic [31:0] a;
        logic [2:0]  sz;
        logic        ev;
        logic [31:0] ed;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Full miss sequence: IDLE miss, `rejects` retried REQ cycles, accept, two WAIT cycles, fill.
    task automatic fill(input logic [31:0] a, input logic [3:0] t, input logic [63:0] d, input int rejects);
        rd_cache = 1'b1; addr = a; mem_size = 3'd2; #1;
        check("miss_no_valid", {31'd0, cache_valid}, 32'd0);
        tick();
        for (int i = 0; i < rejects; i++) begin
            check("retry_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_LOAD});
            check("retry_addr", proc2mem_addr, {a[31:3], 3'b000});
            tick();
        end
        mem2proc_response = t; #1;
        check("req_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_LOAD});
        tick();
        mem2proc_response = 4'd0; #1;
        check("wait_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
        check("wait_no_valid", {31'd0, cache_valid}, 32'd0);
        tick();
        mem2proc_tag = t; mem2proc_data = d;
        tick();
        mem2proc_tag = 4'd0; mem2proc_data = 64'd0;
        exp_misses++;
        #1;
        check("fill_count", miss_count, exp_misses);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h104, 3'b000, 1'b1, 32'h00000044};
        vecs[1]  = '{1'b1, 32'h101, 3'b000, 1'b1, 32'hFFFFFFCC};
        vecs[2]  = '{1'b1, 32'h102, 3'b101, 1'b1, 32'h0000AABB};
        vecs[3]  = '{1'b1, 32'h100, 3'b010, 1'b1, 32'hAABBCCDD};
        vecs[4]  = '{1'b1, 32'h104, 3'b010, 1'b1, 32'h11223344};
        vecs[5]  = '{1'b1, 32'h106, 3'b001, 1'b1, 32'h00001122};
        vecs[6]  = '{1'b1, 32'h100, 3'b001, 1'b1, 32'hFFFFCCDD};
        vecs[7]  = '{1'b1, 32'h107, 3'b100, 1'b1, 32'h00000011};
        vecs[8]  = '{1'b1, 32'h103, 3'b100, 1'b1, 32'h000000AA};
        vecs[9]  = '{1'b1, 32'h103, 3'b000, 1'b1, 32'hFFFFFFAA};
        vecs[10] = '{1'b1, 32'h100, 3'b011, 1'b0, 32'h00000000};
        vecs[11] = '{1'b0, 32'h100, 3'b010, 1'b0, 32'h00000000};

        reset_n = 1'b0; rd_cache = 1'b0; addr = 32'd0; mem_size = 3'd0; squash = 1'b0;
        mem2proc_response = 4'd0; mem2proc_data = 64'd0; mem2proc_tag = 4'd0;
        tick(); tick();
        reset_n = 1'b1; #1;
        check("rst_valid", {31'd0, cache_valid}, 32'd0);
        check("rst_data", cache_data, 32'd0);
        check("rst_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
        check("rst_addr", proc2mem_addr, 32'd0);
        check("rst_count", miss_count, 32'd0);

        // Cold miss with two rejected cycles before acceptance.
        fill(32'h100, 4'd3, LINE_A, 2);
        check("cold_valid", {31'd0, cache_valid}, 32'd1);
        check("cold_data", cache_data, 32'hAABBCCDD);

        foreach (vecs[i]) begin
            rd_cache = vecs[i].rd; addr = vecs[i].a; mem_size = vecs[i].sz; #1;
            check($sformatf("vec%0d_valid", i), {31'd0, cache_valid}, {31'd0, vecs[i].ev});
            check($sformatf("vec%0d_data", i), cache_data, vecs[i].ed);
            check($sformatf("vec%0d_cmd", i), {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
            tick();
        end

        // Conflict: same index, different tag evicts the old line.
        fill(32'h200, 4'd6, LINE_B, 0);
        check("conf_data", cache_data, 32'h99AABBCC);
        addr = 32'h100; #1;
        check("evicted_valid", {31'd0, cache_valid}, 32'd0);
        tick();
        check("evict_req_addr", proc2mem_addr, 32'h100);
        mem2proc_response = 4'd1; tick();
        mem2proc_response = 4'd0; mem2proc_tag = 4'd1; mem2proc_data = LINE_A; tick();
        mem2proc_tag = 4'd0; exp_misses++; #1;
        check("refill_data", cache_data, 32'hAABBCCDD);
        check("refill_count", miss_count, exp_misses);

        // Retry then squash with no acceptance: no fill.
        rd_cache = 1'b1; addr = 32'h40; mem_size = 3'd2; tick();
        for (int i = 0; i < 3; i++) begin
            check("sq_retry_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_LOAD});
            tick();
        end
        squash = 1'b1; tick();
        squash = 1'b0; rd_cache = 1'b0; #1;
        check("sq_idle_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
        check("sq_count", miss_count, exp_misses);
        tick();
        check("sq_still_idle", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});

        // Squash coinciding with acceptance: fill completes on tag 5.
        rd_cache = 1'b1; addr = 32'h40; tick();
        squash = 1'b1; mem2proc_response = 4'd5; tick();
        squash = 1'b0; mem2proc_response = 4'd0; #1;
        check("sqacc_wait_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
        // A hit to another line is still served while the miss is outstanding.
        addr = 32'h104; #1;
        check("busy_hit_data", cache_data, 32'h11223344);
        mem2proc_tag = 4'd5; mem2proc_data = LINE_B; tick();
        mem2proc_tag = 4'd0; addr = 32'h44; exp_misses++; #1;
        check("sqacc_data", cache_data, 32'h55667788);
        check("sqacc_count", miss_count, exp_misses);

        // Reset in WAIT; stale tag 2 afterwards must be ignored.
        addr = 32'h80; tick();
        mem2proc_response = 4'd2; tick();
        mem2proc_response = 4'd0; rd_cache = 1'b0; reset_n = 1'b0; #1;
        check("mid_rst_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
        check("mid_rst_addr", proc2mem_addr, 32'd0);
        check("mid_rst_count", miss_count, 32'd0);
        tick();
        reset_n = 1'b1; mem2proc_tag = 4'd2; mem2proc_data = LINE_A; tick();
        mem2proc_tag = 4'd0; exp_misses = 0; #1;
        check("post_rst_count", miss_count, 32'd0);
        check("post_rst_cmd", {30'd0, proc2mem_command}, {30'd0, CMD_NONE});
        rd_cache = 1'b1; addr = 32'h100; #1;
        check("post_rst_invalid", {31'd0, cache_valid}, 32'd0);
        tick();
        rd_cache = 1'b0; squash = 1'b1; tick();
        squash = 1'b0;

        // Stray tag 7 ignored while waiting for tag 4.
        rd_cache = 1'b1; addr = 32'h80; tick();
        mem2proc_response = 4'd4; tick();
        mem2proc_response = 4'd0; mem2proc_tag = 4'd7; mem2proc_data = LINE_B; tick(); tick();
        check("stray_count", miss_count, 32'd0);
        check("stray_no_valid", {31'd0, cache_valid}, 32'd0);
        mem2proc_tag = 4'd4; mem2proc_data = LINE_A; tick();
        mem2proc_tag = 4'd0; exp_misses++; #1;
        check("tag4_count", miss_count, exp_misses);
        check("tag4_data", cache_data, 32'hAABBCCDD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
